addsub_seq: RTL
===============

Name: addsub_seq

Overview:
- Multi-cycle, parametrised add/subtract unit. It processes N-bit operands in W-bit slices, LSB slice first, and propagates carry through an internal register.
- Adds add-with-carry, subtract-with-borrow, a zero flag and a start/busy/done handshake to the existing combinational add/sub path.
- Serves as the wide-operand arithmetic engine for multi-cycle ALU operations where a full-width carry chain would limit clock rate.

Parameters:
- N, 32, total operand/result width in bits.
- W, 8, slice width processed per cycle. N must be a multiple of W and W <= N; any violation is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request. Sampled only when the block is idle or done.
- A  input  N  first operand, latched on an accepted Start.
- B  input  N  second operand, latched on an accepted Start.
- Subtract  input  1  0 = A+B, 1 = A-B. Latched on an accepted Start.
- UseCarry  input  1  1 = carry-in comes from CarryIn (ADC/SBC). Latched on an accepted Start.
- CarryIn  input  1  external carry; for subtract, 1 means "no borrow". Latched on an accepted Start.
- Busy  output  1  high while slices are being computed.
- Done  output  1  one-cycle pulse when Result and flags are updated.
- Result  output  N  registered result; holds until the next completion.
- FlagN  output  1  Result[N-1].
- FlagZ  output  1  Result == 0.
- FlagC  output  1  carry out of bit N-1. For subtract, 1 = no borrow.
- FlagV  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, at any time): state = IDLE; Busy = 0, Done = 0, Result = 0, all flags = 0; internal carry and slice counter cleared.
- Reset mid-operation: the operation is aborted, no Done is issued, and outputs return to reset values.
- States:
  - IDLE: Start=1 → capture A, Bx = B ^ {N{Subtract}}, and carry c0; counter k=0; go to RUN.
  - RUN: each cycle computes {c, S_k} = A_k + Bx_k + c, where slice k is bits [k*W +: W]. S_k is written into an internal accumulator; k increments. After slice K-1 (K = N/W), go to DONE.
  - DONE: Done=1 for exactly this cycle. Accumulator is copied to Result, flags are updated, then go to IDLE. Start=1 in DONE is accepted exactly as in IDLE (back-to-back operation), and the next state is RUN.
- Carry-in c0:
  - UseCarry=1: c0 = CarryIn.
  - UseCarry=0: c0 = Subtract.
- Busy = 1 exactly in RUN. Start asserted while in RUN is ignored and not queued.
- Latency: Start sampled at edge t; Done high in the cycle after edge t+K. Result and flags are visible from that same cycle. With N=32, W=8: 4 RUN cycles, Done in cycle 5.
- Flag definitions:
  - FlagC: final carry out.
  - FlagV: (A[N-1] == Bx[N-1]) && (Result[N-1] != A[N-1]).
  - FlagN: Result[N-1].
  - FlagZ: Result == 0. FlagZ is computed over the full result, independent of carry-in.
- Result and flags change only in the DONE transition. Operand input changes after acceptance have no effect.
- W == N degenerates to one RUN cycle (Done 2 cycles after Start).
- All arithmetic is unsigned modulo 2^N. No saturation.

Test Plan:
- N=32, W=8; add A=0x0000_0001, B=0xFFFF_FFFF → Result=0x0000_0000, C=1, Z=1, N=0, V=0; Busy high 4 cycles; Done pulses once, in cycle 5 after Start.
- Sub A=0x8000_0000, B=0x0000_0001 → Result=0x7FFF_FFFF, C=1, V=1, N=0, Z=0.
- Sub A=3, B=5 → Result=0xFFFF_FFFE, C=0, N=1, V=0, Z=0.
- ADC A=0xFFFF_FFFF, B=0, UseCarry=1, CarryIn=1 → Result=0, C=1, Z=1. Then SBC A=5, B=2, UseCarry=1, CarryIn=0 → Result=2, C=1.
- Handshake:
  - Start pulsed during RUN with new operands → ignored; the first result is unchanged and there is a single Done.
  - Start held in the DONE cycle → second operation begins immediately, and its Done arrives 5 cycles later.
- Reset:
  - rst_n pulled low during the 2nd RUN cycle → Busy, Done, Result and flags are 0 immediately, and no Done follows.
  - After release, a fresh add 0x1234_5678 + 0x1111_1111 → 0x2345_6789.
  - Repeat with W=32 and confirm Done arrives 2 cycles after Start.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: N-bit operands are processed W bits per cycle, LSB slice first,
// with the inter-slice carry held in a register. Start/Busy/Done handshake; NZCV flags on completion.

module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s   = sum[W-1:0];
    assign co  = sum[W];
endmodule

module addsub_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Subtract,
    input  logic         UseCarry,
    input  logic         CarryIn,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Result,
    output logic         FlagN,
    output logic         FlagZ,
    output logic         FlagC,
    output logic         FlagV
);
    localparam int K  = N / W;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    generate
        if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
            $error("addsub_seq: N must be a non-zero multiple of W with W <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands as latched on an accepted Start; B is stored already inverted for subtract.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] bx;
    } req_t;

    state_t         state, state_nxt;
    req_t           req;
    logic           carry;
    logic [KW-1:0]  k;
    logic [N-1:0]   acc, acc_nxt;
    logic [W-1:0]   a_k, b_k, s_k;
    logic           c_k;
    logic           accept, last;

    assign accept = Start && (state != RUN);
    assign last   = (k == KW'(K - 1));

    always_comb begin
        a_k = req.a[k*W +: W];
        b_k = req.bx[k*W +: W];
    end

    addsub_slice #(.W(W)) u_slice (
        .a  (a_k),
        .b  (b_k),
        .ci (carry),
        .s  (s_k),
        .co (c_k)
    );

    always_comb begin
        acc_nxt          = acc;
        acc_nxt[k*W +: W] = s_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

    // Result and flags are written on the final slice edge so they are valid during the Done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= '0;
            carry  <= 1'b0;
            k      <= '0;
            acc    <= '0;
            Result <= '0;
            FlagN  <= 1'b0;
            FlagZ  <= 1'b0;
            FlagC  <= 1'b0;
            FlagV  <= 1'b0;
        end else if (accept) begin
            req.a  <= A;
            req.bx <= B ^ {N{Subtract}};
            carry  <= UseCarry ? CarryIn : Subtract;
            k      <= '0;
            acc    <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= c_k;
            k     <= last ? '0 : k + 1'b1;
            if (last) begin
                Result <= acc_nxt;
                FlagN  <= acc_nxt[N-1];
                FlagZ  <= ~|acc_nxt;
                FlagC  <= c_k;
                FlagV  <= (req.a[N-1] == req.bx[N-1]) && (acc_nxt[N-1] != req.a[N-1]);
            end
        end
    end
endmodule
